// File: rtl/arm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | arm_pkg : shared types and defaults for the write-back stage     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package arm_pkg;

  localparam int DATA_W               = 32;
  localparam int REG_W                = 4;
  localparam int LOAD_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_WRITE     = 2'd2
  } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_load_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_load_timer : counts load-wait cycles, flags the final one     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module wb_load_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int             CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Expiry fires on the LIMIT-th idle wait cycle, so the waiter sees LIMIT chances for data.
  assign expired = tick && !clear && (count_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_stage : write-back stage with load wait and timeout abort     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module wb_stage
  import arm_pkg::*;
#(
  parameter int LOAD_TIMEOUT = LOAD_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WB_EN_in,
  input  logic              MEM_R_EN_in,
  input  logic [DATA_W-1:0] ALU_Res,
  input  logic [REG_W-1:0]  Dest,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [REG_W-1:0]  Dest_wb,
  output logic [DATA_W-1:0] Result_WB,
  output logic              writeBackEn,
  output logic              freeze,
  output logic              load_err
);

  wb_state_e         state_q, state_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              load_err_q, load_err_d;
  logic              accept;
  logic              timer_clear;
  logic              timer_tick;
  logic              timer_expired;

  assign in_ready    = (state_q != ST_LOAD_WAIT);
  assign freeze      = ~in_ready;
  assign accept      = in_valid && in_ready;
  assign timer_clear = (state_q != ST_LOAD_WAIT);
  assign timer_tick  = (state_q == ST_LOAD_WAIT) && !mem_rvalid;

  wb_load_timer #(
    .LIMIT (LOAD_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .tick    (timer_tick),
    .expired (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    result_d   = result_q;
    load_err_d = load_err_q;
    case (state_q)
      ST_LOAD_WAIT: begin
        // Data arriving on the last allowed cycle still wins over the abort.
        if (mem_rvalid) begin
          result_d = mem_rdata;
          state_d  = ST_WRITE;
        end else if (timer_expired) begin
          load_err_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          dest_d = Dest;
          if (WB_EN_in && MEM_R_EN_in) begin
            state_d = ST_LOAD_WAIT;
          end else if (WB_EN_in) begin
            result_d = ALU_Res;
            state_d  = ST_WRITE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dest_q     <= '0;
      result_q   <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      result_q   <= result_d;
      load_err_q <= load_err_d;
    end
  end

  assign writeBackEn = (state_q == ST_WRITE);
  assign Dest_wb     = dest_q;
  assign Result_WB   = result_q;
  assign load_err    = load_err_q;

endmodule
`default_nettype wire
